bcd_mod_counter: RTL and testbench

Parametrised, cascadable BCD counter with programmable modulus, up/down direction, synchronous clear and validated parallel load. Generalises the team's fixed mod-60 BCD counter to any digit count and modulus, e.g. mod-60 for seconds/minutes, mod-24 for hours, mod-1000 for ms. Used in clock/timer datapaths. Digit instances chain through tc into the next stage's en.

---
 rtl/bcd_mod_counter.sv | 165 ++++++++++++++++
 tb/tb_bcd_mod_counter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: cascadable packed-BCD counter with programmable modulus,
// up/down direction, synchronous clear and a validated parallel load.
// Digit arithmetic is done per BCD nibble; no binary conversion is in the datapath.
// Optional feature macro: PRESCALE_EN builds an enable prescaler that divides
// en by PRESCALE. Without it, tick is constant 1.
`timescale 1ns/1ps

module bcd_mod_counter #(
  parameter int DIGITS   = 2,
  parameter int MODULUS  = 60,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  cout,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Elaboration-time encoding of a binary constant into packed BCD.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Largest legal count; it also bounds accepted loads, so MODULUS == 10^DIGITS
  // never needs a value wider than the count itself.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // PRESCALE is validated even when the prescaler is compiled out, so a bad
  // configuration is caught before the feature is switched on.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_mod_counter: DIGITS must be 1..8");
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be 2..10^DIGITS");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("bcd_mod_counter: PRESCALE must be 1..65535");
  end

  logic         tick;
  logic         is_max;
  logic         is_zero;
  logic         wrap;
  logic         digits_ok;
  logic         load_ok;
  logic         carry;
  logic [W-1:0] step_val;

  assign is_max  = (cnt == MAX_BCD);
  assign is_zero = (cnt == '0);
  assign wrap    = up_dn ? is_max : is_zero;
  assign tc      = en & tick & wrap;

`ifdef PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  logic [15:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: advances while en is high, restarts on clear or an accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clr || (load && load_ok)) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Load validation: every nibble must be a decimal digit and the value in range.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    digits_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  assign load_ok = digits_ok && (load_val <= MAX_BCD);

  // Next count for one step: per-digit increment/decrement with ripple carry,
  // then substitution of the wrap value at the ends of the range.
  always_comb begin
    step_val = cnt;
    carry    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (up_dn) begin
          if (cnt[4*k +: 4] == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = cnt[4*k +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (cnt[4*k +: 4] == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = cnt[4*k +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    if (up_dn && is_max) begin
      step_val = '0;
    end else if (!up_dn && is_zero) begin
      step_val = MAX_BCD;
    end
  end

  // Count register with clr > load > count > hold priority; cout and load_err
  // are single-cycle pulses cleared on every other edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only the architectural state is reset here, asynchronously; the
    // non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      cnt      <= '0;
      cout     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cout     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (load) begin
        if (load_ok) cnt <= load_val;
        else         load_err <= 1'b1;
      end else if (en && tick) begin
        cnt  <= step_val;
        cout <= wrap;
      end
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: three instances (mod-60, mod-24, mod-1000) checked
// every cycle against an integer-valued model, plus directed literal checks.
`timescale 1ns/1ps

module tb_bcd_mod_counter;

`ifdef PRESCALE_EN
  localparam int PRE   = 4;
  localparam bit PS_ON = 1'b1;
`else
  localparam int PRE   = 1;
  localparam bit PS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: mod-60, two digits
  logic        en0, up0, clr0, ld0, tc0, cout0, le0;
  logic [7:0]  lv0, cnt0;
  // Instance 1: mod-24, two digits, optionally cascaded from instance 0
  logic        en1_drv, casc, en1, up1, clr1, ld1, tc1, cout1, le1;
  logic [7:0]  lv1, cnt1;
  // Instance 2: mod-1000, three digits (modulus equals 10^DIGITS)
  logic        en2, up2, clr2, ld2, tc2, cout2, le2;
  logic [11:0] lv2, cnt2;

  assign en1 = casc ? tc0 : en1_drv;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .PRESCALE(PRE)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .up_dn(up0), .clr(clr0), .load(ld0),
    .load_val(lv0), .cnt(cnt0), .tc(tc0), .cout(cout0), .load_err(le0));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .PRESCALE(PRE)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .up_dn(up1), .clr(clr1), .load(ld1),
    .load_val(lv1), .cnt(cnt1), .tc(tc1), .cout(cout1), .load_err(le1));

  bcd_mod_counter #(.DIGITS(3), .MODULUS(1000), .PRESCALE(PRE)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up_dn(up2), .clr(clr2), .load(ld2),
    .load_val(lv2), .cnt(cnt2), .tc(tc2), .cout(cout2), .load_err(le2));

  // ---------------- behavioural model (integer count value) ----------------
  typedef struct packed {
    int   v;
    int   p;
    logic cout;
    logic lerr;
  } mstate_t;

  mstate_t m0, m1, m2;

  function automatic logic [31:0] bcd_of(input int v, input int digits);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_tc(input mstate_t s, input logic en, input logic up, input int m);
    logic tick;
    tick = !PS_ON || (s.p == PRE - 1);
    return en && tick && (up ? (s.v == m - 1) : (s.v == 0));
  endfunction

  function automatic mstate_t next_state(input mstate_t s, input logic en, input logic up,
                                         input logic clr, input logic ld, input logic [31:0] lv,
                                         input int digits, input int m);
    mstate_t n;
    int      val;
    logic    ok;
    logic    tick;
    n      = s;
    n.cout = 1'b0;
    n.lerr = 1'b0;
    tick   = !PS_ON || (s.p == PRE - 1);
    if (clr) begin
      n.v = 0;
      n.p = 0;
    end else if (ld) begin
      val = 0;
      ok  = 1'b1;
      for (int k = digits - 1; k >= 0; k--) begin
        if (lv[4*k +: 4] > 4'd9) ok = 1'b0;
        val = val * 10 + int'(lv[4*k +: 4]);
      end
      if (ok && val < m) begin
        n.v = val;
        n.p = 0;
      end else begin
        n.lerr = 1'b1;
        if (en && PS_ON) n.p = tick ? 0 : s.p + 1;
      end
    end else if (en) begin
      if (PS_ON) n.p = tick ? 0 : s.p + 1;
      if (tick) begin
        if (up) begin
          n.v    = (s.v + 1) % m;
          n.cout = (s.v == m - 1);
        end else begin
          n.v    = (s.v == 0) ? m - 1 : s.v - 1;
          n.cout = (s.v == 0);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
      m2 <= '0;
    end else begin
      m0 <= next_state(m0, en0, up0, clr0, ld0, {24'd0, lv0}, 2, 60);
      m1 <= next_state(m1, casc ? model_tc(m0, en0, up0, 60) : en1_drv,
                       up1, clr1, ld1, {24'd0, lv1}, 2, 24);
      m2 <= next_state(m2, en2, up2, clr2, ld2, {20'd0, lv2}, 3, 1000);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all outputs of all instances against the model, mid-cycle.
  always @(negedge clk) begin
    check("cnt0",  {24'd0, cnt0}, bcd_of(m0.v, 2));
    check("tc0",   {31'd0, tc0},  {31'd0, model_tc(m0, en0, up0, 60)});
    check("cout0", {31'd0, cout0}, {31'd0, m0.cout});
    check("lerr0", {31'd0, le0},  {31'd0, m0.lerr});
    check("cnt1",  {24'd0, cnt1}, bcd_of(m1.v, 2));
    check("tc1",   {31'd0, tc1},
          {31'd0, model_tc(m1, casc ? model_tc(m0, en0, up0, 60) : en1_drv, up1, 24)});
    check("cout1", {31'd0, cout1}, {31'd0, m1.cout});
    check("lerr1", {31'd0, le1},  {31'd0, m1.lerr});
    check("cnt2",  {20'd0, cnt2}, bcd_of(m2.v, 3));
    check("tc2",   {31'd0, tc2},  {31'd0, model_tc(m2, en2, up2, 1000)});
    check("cout2", {31'd0, cout2}, {31'd0, m2.cout});
    check("lerr2", {31'd0, le2},  {31'd0, m2.lerr});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mix of in-range values, values straddling the modulus and raw random bits.
  function automatic logic [31:0] rand_lv(input int digits, input int m);
    int sel;
    sel = $urandom_range(0, 2);
    if (sel == 0)      return bcd_of($urandom_range(0, m - 1), digits);
    else if (sel == 1) return bcd_of(m - 1 + $urandom_range(0, 1), digits);
    else               return 32'($urandom);
  endfunction

  int pulses;
  int pulse_step;
  logic [31:0] tmp;

  initial begin
    en0 = 0; up0 = 1; clr0 = 0; ld0 = 0; lv0 = '0;
    en1_drv = 0; casc = 0; up1 = 1; clr1 = 0; ld1 = 0; lv1 = '0;
    en2 = 0; up2 = 1; clr2 = 0; ld2 = 0; lv2 = '0;
    rst_n = 0;
    cyc(2);
    check("rst_cnt0", {24'd0, cnt0}, 32'h0);
    check("rst_cout0", {31'd0, cout0}, 32'h0);
    check("rst_lerr0", {31'd0, le0}, 32'h0);
    rst_n = 1;

`ifndef PRESCALE_EN
    // Up count through the mod-60 wrap
    en0 = 1; up0 = 1;
    cyc(59);
    check("up_59", {24'd0, cnt0}, 32'h59);
    check("up_tc_at_59", {31'd0, tc0}, 32'h1);
    cyc(1);
    check("up_wrap_cnt", {24'd0, cnt0}, 32'h00);
    check("up_wrap_cout", {31'd0, cout0}, 32'h1);
    cyc(1);
    check("up_after_cnt", {24'd0, cnt0}, 32'h01);
    check("up_after_cout", {31'd0, cout0}, 32'h0);

    // Down count from 0
    clr0 = 1; cyc(1); clr0 = 0; up0 = 0;
    cyc(1);
    check("dn_wrap_cnt", {24'd0, cnt0}, 32'h59);
    check("dn_wrap_cout", {31'd0, cout0}, 32'h1);
    cyc(9);
    check("dn_50", {24'd0, cnt0}, 32'h50);
    check("dn_cout_low", {31'd0, cout0}, 32'h0);
    cyc(1);
    check("dn_49", {24'd0, cnt0}, 32'h49);

    // Load validation on the mod-24 instance
    en1_drv = 0; ld1 = 1; lv1 = 8'h23;
    cyc(1);
    check("ld23_cnt", {24'd0, cnt1}, 32'h23);
    check("ld23_err", {31'd0, le1}, 32'h0);
    lv1 = 8'h24;
    cyc(1);
    check("ld24_cnt", {24'd0, cnt1}, 32'h23);
    check("ld24_err", {31'd0, le1}, 32'h1);
    lv1 = 8'h1A;
    cyc(1);
    check("ld1A_cnt", {24'd0, cnt1}, 32'h23);
    check("ld1A_err", {31'd0, le1}, 32'h1);
    ld1 = 0;
    cyc(1);
    check("ld_err_drop", {31'd0, le1}, 32'h0);
    clr1 = 1; ld1 = 1; lv1 = 8'h05;
    cyc(1);
    check("clr_ld_cnt", {24'd0, cnt1}, 32'h00);
    check("clr_ld_err", {31'd0, le1}, 32'h0);
    clr1 = 0; ld1 = 0;

    // Cascade: minutes (mod-60) into hours (mod-24) over a full day
    clr0 = 1; clr1 = 1; up0 = 1; up1 = 1; en0 = 1; casc = 1;
    cyc(1);
    clr0 = 0; clr1 = 0;
    pulses = 0; pulse_step = 0;
    for (int i = 1; i <= 1440; i++) begin
      cyc(1);
      if (cout1) begin
        pulses++;
        pulse_step = i;
      end
      if (i == 1439) begin
        check("casc_lo_59", {24'd0, cnt0}, 32'h59);
        check("casc_hi_23", {24'd0, cnt1}, 32'h23);
        check("casc_tc_hi", {31'd0, tc1}, 32'h1);
      end
    end
    check("casc_lo_00", {24'd0, cnt0}, 32'h00);
    check("casc_hi_00", {24'd0, cnt1}, 32'h00);
    check("casc_pulses", pulses, 32'd1);
    check("casc_pulse_step", pulse_step, 32'd1440);
    casc = 0;

    // Asynchronous reset between edges
    clr0 = 1; cyc(1); clr0 = 0; en0 = 1; up0 = 1;
    cyc(37);
    check("pre_rst_37", {24'd0, cnt0}, 32'h37);
    #3;
    rst_n = 0;
    #1;
    check("arst_cnt", {24'd0, cnt0}, 32'h00);
    check("arst_cout", {31'd0, cout0}, 32'h0);
    check("arst_lerr", {31'd0, le0}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc(1);
    check("arst_resume", {24'd0, cnt0}, 32'h01);
`else
    // Prescaled counting: one step every PRE enabled clocks
    en0 = 1; up0 = 1; clr0 = 1;
    cyc(1);
    clr0 = 0;
    cyc(3);
    check("ps_hold3", {24'd0, cnt0}, 32'h00);
    cyc(1);
    check("ps_step1", {24'd0, cnt0}, 32'h01);
    en0 = 0;
    cyc(3);
    check("ps_frozen", {24'd0, cnt0}, 32'h01);
    en0 = 1;
    cyc(3);
    check("ps_hold_again", {24'd0, cnt0}, 32'h01);
    cyc(1);
    check("ps_step2", {24'd0, cnt0}, 32'h02);
`endif

    // Randomised phase, all instances independent
    for (int c = 0; c < 3000; c++) begin
      en0 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up0 = ~up0;
      clr0 = ($urandom_range(0, 31) == 0);
      ld0  = ($urandom_range(0, 11) == 0);
      tmp = rand_lv(2, 60);   lv0 = tmp[7:0];
      en1_drv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up1 = ~up1;
      clr1 = ($urandom_range(0, 31) == 0);
      ld1  = ($urandom_range(0, 11) == 0);
      tmp = rand_lv(2, 24);   lv1 = tmp[7:0];
      en2 = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up2 = ~up2;
      clr2 = ($urandom_range(0, 63) == 0);
      ld2  = ($urandom_range(0, 11) == 0);
      tmp = rand_lv(3, 1000); lv2 = tmp[11:0];
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
